mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Registers the EX-to-MEM bus and receives the synchronous data-SRAM read data one cycle after EX issued the request.
- Aligns, extracts and sign/zero-extends load data, selects the register-file write value, and drives MEM-to-WB and MEM-to-RF forwarding buses.
- Holds SRAM read data across MEM stalls so a load result is never lost.

Parameters:
- EX_TO_MEM_WD, 147, input bus width: mem_op[146:142], hilo_bus[141:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- MEM_TO_WB_WD, 136, {hilo_bus[135:70], pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- MEM_TO_RF_WD, 104, {hilo_bus[103:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- STALL_WD, 6, stall bus width; bit 3 = MEM, bit 4 = WB; 1 = Stop.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_WD  pipeline stall vector
- ex_to_mem_bus  in  EX_TO_MEM_WD  EX stage output
- data_sram_rdata  in  32  SRAM read word; valid the cycle after EX asserted en with wen=0
- mem_to_wb_bus  out  MEM_TO_WB_WD  to WB
- mem_to_rf_bus  out  MEM_TO_RF_WD  forwarding to ID

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high. Asserting rst immediately clears bus_r, buf_valid and buf_data to 0 without waiting for a clock edge. Both output buses are then all-zero.

Pipeline register bus_r, updated on each posedge when not in reset:
- stall[3]=1 and stall[4]=0: load 0 (bubble).
- Else if stall[3]=0: load ex_to_mem_bus.
- Else: hold.

mem_op is one-hot {lb, lbu, lh, lhu, lw}, with lb at bit 4 and lw at bit 0. It is 0 for stores and non-memory instructions.

Read-data hold buffer (buf_valid, buf_data):
- stall[3]=0, or the bubble condition holds: buf_valid<=0 on the edge.
- Else (MEM held), buf_valid=0, data_ram_en=1 and data_ram_wen=4'b0: buf_data<=data_sram_rdata, buf_valid<=1.
- Else: hold.
- Effective read word is rd = buf_valid ? buf_data : data_sram_rdata.
- Net effect: the value present in the first MEM cycle is frozen for the whole stall.

Load extraction (all combinational), with a = ex_result[1:0]:
- lb / lbu: byte = rd[8a+7:8a]. lb sign-extends to 32 bits; lbu zero-extends.
- lh / lhu: half = a[1] ? rd[31:16] : rd[15:0]. lh sign-extends; lhu zero-extends. a[0] is ignored.
- lw: rd unchanged; a is ignored. Misaligned addresses raise no exception in this block.
- sel_rf_res=1 with mem_op=0: treat as lw.

Result selection and outputs:
- rf_wdata = sel_rf_res ? load_data : ex_result.
- hilo_bus, pc, rf_we and rf_waddr pass through from bus_r unchanged.
- Both outputs are purely combinational from bus_r, buf and data_sram_rdata. There is no extra latency.
- A store (wen≠0) drives rf_wdata = ex_result; its rf_we is whatever EX set, normally 0.

Latency and corner cases:
- An instruction appears on the outputs the cycle after its EX cycle. A load's data is valid in that same cycle.
- Simultaneous bubble and valid buffer: the bubble wins and buf_valid clears.
- Reset during a stalled load discards both bus_r and the buffer.

Test Plan:
- Reset: drive nonzero bus, clock twice, then assert rst between edges. Both output buses must read 0 before the next edge, and stay 0 until the first edge after rst deasserts.
- Byte loads: lb with ex_result=0x00001003 and rdata=0x80FF1234 → rf_wdata=0xFFFFFF80. lbu with the same inputs → 0x00000080. lb with a=1 → 0x00000012.
- Half loads: lh with a=2 and rdata=0x80017FFF → 0xFFFF8001. lhu with a=0 → 0x00007FFF.
- Stall hold: issue lw with rdata=0x12345678 in the first MEM cycle, then stall=6'b011111 for 3 cycles while rdata changes to 0xDEADBEEF. rf_wdata must stay 0x12345678 every cycle. After release, buf_valid=0 and the next load uses live rdata.
- Bubble: stall=6'b001111 (stall[3]=1, stall[4]=0) for one edge → next cycle mem_to_wb_bus=0 and rf_we=0. Releasing the stall loads the pending EX bus.
- Passthrough: sel_rf_res=0, ex_result=0x00000055, rf_we=1, waddr=5'd9, hilo_bus with hi_we=1 and hi=0xAAAA0000 → both outputs carry exactly these values, with pc matching the input.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX bus, extracts and extends load data, and drives the WB and RF-forward buses.
// Outputs are combinational from the stage register (1 cycle after EX); stall[3] holds the stage, and a held load keeps its SRAM word.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 147,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_RF_WD = 104,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    typedef struct packed {
        logic [4:0]  mem_op;     // {lb, lbu, lh, lhu, lw}
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    ex_mem_t     bus_q, bus_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic        mem_stop;
    logic        bubble;
    logic [31:0] rd_word;
    logic [1:0]  addr_lo;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_stall_bits;

    assign mem_stop          = stall[3];
    assign bubble            = stall[3] & ~stall[4];
    assign unused_stall_bits = ^{stall[STALL_WD-1:5], stall[2:0]};

    always_comb begin
        bus_d = bus_q;
        if (bubble) begin
            bus_d = '0;
        end else if (!mem_stop) begin
            bus_d = ex_mem_t'(ex_to_mem_bus);
        end
    end

    // Capture the SRAM word on the first held cycle only, so a stalled load keeps its original data.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (!mem_stop || bubble) begin
            buf_valid_d = 1'b0;
        end else if (!buf_valid_q && bus_q.data_ram_en && (bus_q.data_ram_wen == 4'b0000)) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            bus_q       <= bus_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign rd_word = buf_valid_q ? buf_data_q : data_sram_rdata;
    assign addr_lo = bus_q.ex_result[1:0];

    always_comb begin
        byte_sel = rd_word[7:0];
        case (addr_lo)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    assign half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    // lw, and sel_rf_res with no mem_op, fall through to the raw word.
    always_comb begin
        load_data = rd_word;
        if (bus_q.mem_op[4]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (bus_q.mem_op[3]) begin
            load_data = {24'h0, byte_sel};
        end else if (bus_q.mem_op[2]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (bus_q.mem_op[1]) begin
            load_data = {16'h0, half_sel};
        end
    end

    assign rf_wdata = bus_q.sel_rf_res ? load_data : bus_q.ex_result;

    assign mem_to_wb_bus = {bus_q.hilo_bus, bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {bus_q.hilo_bus, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};

endmodule
